// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pkg
// Description : Shared types and helpers for the servo PWM array: the motion
//               command encoding and the command-to-pulse-width decode.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

  // Two-bit motion command carried on the command port
  typedef enum logic [1:0] {
    CMD_OFF  = 2'b00,
    CMD_FWD  = 2'b01,
    CMD_BACK = 2'b10,
    CMD_STOP = 2'b11
  } cmd_code_e;

  // Pulse width a channel heads toward for a given command. OFF shares the
  // STOP width so a re-enabled channel starts from neutral.
  function automatic int unsigned width_decode(
    input cmd_code_e   code,
    input int unsigned back_w,
    input int unsigned stop_w,
    input int unsigned fwd_w
  );
    int unsigned w;
    w = stop_w;
    case (code)
      CMD_FWD:  w = fwd_w;
      CMD_BACK: w = back_w;
      default:  w = stop_w;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_slew.sv
`default_nettype none
// ============================================================================
// Module      : servo_slew
// Description : One PWM channel. Holds the shadow and active command, slews
//               the pulse width toward the commanded target once per frame
//               and compares it against the shared frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_slew
  import servo_pkg::*;
#(
  parameter int CNT_W  = 12,
  parameter int BACK_W = 10,
  parameter int STOP_W = 15,
  parameter int FWD_W  = 20,
  parameter int STEP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  cmd_code_e        code_i,
  input  logic             boundary_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             pwm_o
);

  localparam logic [CNT_W-1:0] C_STOP_W = CNT_W'(STOP_W);
  localparam logic [CNT_W-1:0] C_STEP   = CNT_W'(STEP);

  cmd_code_e        shadow_q;
  cmd_code_e        active_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] width_d;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] diff;

  // The target follows the shadow code so the width starts moving at the
  // same boundary that makes the new command active.
  assign target = CNT_W'(width_decode(shadow_q, BACK_W, STOP_W, FWD_W));

  // Next width: jump when unlimited, else move at most STEP toward the
  // target; the remaining distance is compared first so nothing wraps.
  always_comb begin
    width_d = target;
    diff    = '0;
    if (STEP != 0) begin
      if (target > width_q) begin
        diff    = target - width_q;
        width_d = (diff > C_STEP) ? (width_q + C_STEP) : target;
      end else begin
        diff    = width_q - target;
        width_d = (diff > C_STEP) ? (width_q - C_STEP) : target;
      end
    end
  end

  // Command capture: the last accepted write wins, and it only reaches the
  // output stage at a frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= CMD_OFF;
      active_q <= CMD_OFF;
    end else begin
      if (wr_en_i) begin
        shadow_q <= code_i;
      end
      if (boundary_i) begin
        active_q <= shadow_q;
      end
    end
  end

  // Width register, updated once per frame so a pulse is never cut short.
  always_ff @(posedge clk) begin
    if (reset) begin
      width_q <= C_STOP_W;
    end else if (boundary_i) begin
      width_q <= width_d;
    end
  end

  // All inputs are registers, so this compare cannot glitch.
  assign pwm_o = (active_q != CMD_OFF) && (count_i < width_q);

endmodule
`default_nettype wire

// File: rtl/servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_array
// Description : Multi-channel frame-aligned servo/ESC pulse generator.
//               Shared prescaler and frame counter, command handshake that
//               stalls only in the boundary cycle, one servo_slew per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CNT_W    = 12,
  parameter int PERIOD   = 200,
  parameter int TICK_DIV = 1,
  parameter int BACK_W   = 10,
  parameter int STOP_W   = 15,
  parameter int FWD_W    = 20,
  parameter int STEP     = 0,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CH_W-1:0] cmd_ch,
  input  logic [1:0]      cmd_code,
  output logic [NCH-1:0]  pwm,
  output logic            frame_start
);

  localparam int               PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PERIOD - 1);

  // Reject parameter sets the counter and compare cannot represent.
  if (NCH < 1 || NCH > 8) begin : g_chk_nch
    $error("servo_pwm_array: NCH must be in 1..8");
  end
  if (PERIOD < 1 || TICK_DIV < 1) begin : g_chk_period
    $error("servo_pwm_array: PERIOD and TICK_DIV must be at least 1");
  end
  if (longint'(PERIOD) >= (longint'(1) << CNT_W)) begin : g_chk_cnt_w
    $error("servo_pwm_array: PERIOD must be below 2**CNT_W");
  end
  if (BACK_W > PERIOD || STOP_W > PERIOD || FWD_W > PERIOD) begin : g_chk_widths
    $error("servo_pwm_array: pulse widths must not exceed PERIOD");
  end

  logic [PRE_W-1:0] prescale_q;
  logic [CNT_W-1:0] count_q;
  logic             frame_start_q;
  logic             tick;
  logic             boundary;
  logic             accept;

  assign tick        = (prescale_q == C_PRE_LAST);
  assign boundary    = tick && (count_q == C_CNT_LAST);
  // Stalling commands in the boundary cycle keeps a shadow write from racing
  // the shadow-to-active copy.
  assign cmd_ready   = !boundary;
  assign accept      = cmd_valid && cmd_ready;
  assign frame_start = frame_start_q;

  // Prescaler: one counter step every TICK_DIV clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
    end else if (tick) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_q + PRE_W'(1);
    end
  end

  // Frame counter: 0..PERIOD-1, advancing on each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (tick) begin
      if (count_q == C_CNT_LAST) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Frame-start marker: high for the first count-0 cycle after a boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= boundary;
    end
  end

  // One channel per PWM output; out-of-range channel numbers match nothing
  // and are silently dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = accept && (cmd_ch == CH_W'(i));

    servo_slew #(
      .CNT_W  (CNT_W),
      .BACK_W (BACK_W),
      .STOP_W (STOP_W),
      .FWD_W  (FWD_W),
      .STEP   (STEP)
    ) u_slew (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (wr_en),
      .code_i     (cmd_code_e'(cmd_code)),
      .boundary_i (boundary),
      .count_i    (count_q),
      .pwm_o      (pwm[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_array
// Description : Directed bench for servo_pwm_array. Four instances share the
//               clock: default, STEP=2, TICK_DIV=3 and NCH=3. Expected pulse
//               widths come from a small frame model through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_array;
  import servo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rst2;
  logic       v01, v3, v2;
  logic       ch01, ch2;
  logic [1:0] ch3;
  logic [1:0] code, code2;
  logic [1:0] pwm0, pwm1, pwm2;
  logic [2:0] pwm3;
  logic       fs0, fs1, fs2, fs3;
  logic       rdy0, rdy1, rdy2, rdy3;

  servo_pwm_array u0 (
    .clk(clk), .reset(reset), .cmd_valid(v01), .cmd_ready(rdy0), .cmd_ch(ch01),
    .cmd_code(code), .pwm(pwm0), .frame_start(fs0));

  servo_pwm_array #(.STEP(2)) u1 (
    .clk(clk), .reset(reset), .cmd_valid(v01), .cmd_ready(rdy1), .cmd_ch(ch01),
    .cmd_code(code), .pwm(pwm1), .frame_start(fs1));

  servo_pwm_array #(.TICK_DIV(3)) u2 (
    .clk(clk), .reset(rst2), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_ch(ch2),
    .cmd_code(code2), .pwm(pwm2), .frame_start(fs2));

  servo_pwm_array #(.NCH(3)) u3 (
    .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_ch(ch3),
    .cmd_code(code), .pwm(pwm3), .frame_start(fs3));

  int total = 0;
  int fails = 0;
  int exp_q[$];
  int u2_q[$];
  // Model state per instance (0=u0, 1=u1, 2=u3) and channel
  int m_sh[3][3];
  int m_act[3][3];
  int m_w[3][3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int dec(input int c);
    case (c)
      1:       return 20;
      2:       return 10;
      default: return 15;
    endcase
  endfunction

  function automatic logic pbit(input int d, input int c);
    case (d)
      0:       return (c < 2) ? pwm0[c[0]] : 1'b0;
      1:       return (c < 2) ? pwm1[c[0]] : 1'b0;
      default: return pwm3[c[1:0]];
    endcase
  endfunction

  // Frame boundary in the model: active takes the shadow, width slews.
  task automatic model_boundary();
    int t, w, st;
    for (int d = 0; d < 3; d++) begin
      st = (d == 1) ? 2 : 0;
      for (int c = 0; c < 3; c++) begin
        t = dec(m_sh[d][c]);
        w = m_w[d][c];
        if (st == 0)     w = t;
        else if (t > w)  w = (t - w > st) ? w + st : t;
        else             w = (w - t > st) ? w - st : t;
        m_w[d][c]   = w;
        m_act[d][c] = m_sh[d][c];
      end
    end
  endtask

  task automatic push_exp();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 3; c++)
        exp_q.push_back((m_act[d][c] != 0) ? m_w[d][c] : 0);
  endtask

  task automatic drive(input int ch, input int cd, input int j);
    v01  = (ch < 2);
    ch01 = ((ch % 2) == 1);
    v3   = (ch < 4);
    ch3  = 2'(ch);
    code = 2'(cd);
    // Count 199 is the boundary cycle: the write is stalled there.
    if (j != 199) begin
      if (ch < 2) begin
        m_sh[0][ch] = cd;
        m_sh[1][ch] = cd;
      end
      if (ch < 3) m_sh[2][ch] = cd;
    end
  endtask

  // One frame of the TICK_DIV=1 instances, starting at a count-0 negedge,
  // with up to two commands at given frame offsets.
  task automatic frame(input int f, input int ai, input int ac, input int acd,
                       input int bi, input int bc, input int bcd);
    int   e[9];
    int   hi[9];
    int   bad[3];
    int   rl, fsn, k;
    logic b;
    rl = -1;
    fsn = 0;
    for (int n = 0; n < 9; n++) begin
      e[n]  = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      hi[n] = 0;
    end
    for (int d = 0; d < 3; d++) bad[d] = 0;
    for (int j = 0; j < 200; j++) begin
      for (int d = 0; d < 3; d++) begin
        for (int c = 0; c < 3; c++) begin
          k = d * 3 + c;
          b = pbit(d, c);
          hi[k] += int'(b);
          if (b !== (j < e[k])) bad[d]++;
        end
      end
      fsn += int'(fs0);
      if (!rdy0 && rl < 0) rl = j;
      if (j == ai)      drive(ac, acd, j);
      else if (j == bi) drive(bc, bcd, j);
      else begin
        v01 = 1'b0;
        v3  = 1'b0;
      end
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 3; c++)
        if (d == 2 || c < 2)
          chk($sformatf("f%0d_width_d%0d_c%0d", f, d, c), hi[d * 3 + c], e[d * 3 + c]);
    for (int d = 0; d < 3; d++)
      chk($sformatf("f%0d_shape_d%0d", f, d), bad[d], 0);
    chk($sformatf("f%0d_ready_low_at", f), rl, 199);
    chk($sformatf("f%0d_frame_start_count", f), fsn, 1);
    chk($sformatf("f%0d_next_frame_start", f), fs0, 1);
    model_boundary();
    push_exp();
  endtask

  initial begin
    int fsk, nz, rlk, wt, len, hi2;
    reset = 1'b1; rst2 = 1'b1;
    v01 = 1'b0; v3 = 1'b0; v2 = 1'b0;
    ch01 = 1'b0; ch3 = 2'd0; ch2 = 1'b0; code = 2'd0; code2 = 2'd0;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 3; c++) begin
        m_sh[d][c] = 0; m_act[d][c] = 0; m_w[d][c] = 15;
      end

    repeat (3) @(negedge clk);
    chk("rst_pwm0", pwm0, 0);
    chk("rst_pwm3", pwm3, 0);
    chk("rst_pwm2", pwm2, 0);
    chk("rst_frame_start", fs0, 0);
    chk("rst_ready", rdy0, 1);
    chk("rst_ready_u2", rdy2, 1);

    // Release reset; u2 gets FWD on ch0 in its first cycle.
    reset = 1'b0; rst2 = 1'b0;
    v2 = 1'b1; ch2 = 1'b0; code2 = 2'b01;
    u2_q.push_back(600);
    u2_q.push_back(60);
    fsk = -1; nz = 0; rlk = -1;
    for (int k = 1; k <= 400 && fsk < 0; k++) begin
      @(negedge clk);
      v2 = 1'b0;
      if ({pwm0, pwm1, pwm3} !== 7'd0) nz++;
      if (!rdy0 && rlk < 0) rlk = k;
      if (fs0) fsk = k;
    end
    chk("first_frame_start_cycle", fsk, 200);
    chk("reset_frame_pwm_high_cycles", nz, 0);
    chk("reset_frame_ready_low_cycle", rlk, 199);

    push_exp();
    frame(0, 50, 0, 1, -1, 0, 0);     // FWD ch0 at count 50
    frame(1, 10, 1, 2, 100, 1, 3);    // BACK then STOP on ch1
    frame(2, 30, 0, 3, -1, 0, 0);     // STOP ch0
    frame(3, -1, 0, 0, -1, 0, 0);
    frame(4, 60, 0, 2, -1, 0, 0);     // BACK ch0
    frame(5, 199, 1, 1, -1, 0, 0);    // FWD ch1 held across the boundary
    chk("hold_ready_after_boundary", rdy0, 1);
    frame(6, 0, 1, 1, 120, 3, 1);     // held command lands; ch 3 dropped
    frame(7, -1, 0, 0, -1, 0, 0);
    frame(8, 5, 0, 0, -1, 0, 0);      // OFF ch0
    frame(9, -1, 0, 0, -1, 0, 0);

    // TICK_DIV=3 instance: frame and pulse length in clocks.
    wt = 0;
    while (!fs2 && wt < 700) begin
      @(negedge clk);
      wt++;
    end
    chk("u2_sync_frame_start", fs2, 1);
    len = 0; hi2 = 0;
    do begin
      hi2 += int'(pwm2[0]);
      @(negedge clk);
      len++;
    end while (!fs2 && len < 700);
    chk("u2_frame_len", len, (u2_q.size() > 0) ? u2_q.pop_front() : -1);
    chk("u2_pulse_len", hi2, (u2_q.size() > 0) ? u2_q.pop_front() : -1);

    // Reset in the middle of a pulse.
    repeat (30) @(negedge clk);
    chk("u2_mid_pulse_high", pwm2[0], 1);
    rst2 = 1'b1;
    @(negedge clk);
    chk("u2_reset_pwm", pwm2, 0);
    chk("u2_reset_frame_start", fs2, 0);
    chk("u2_reset_ready", rdy2, 1);
    rst2 = 1'b0;
    len = 0; nz = 0;
    do begin
      @(negedge clk);
      len++;
      if (pwm2 !== 2'd0) nz++;
    end while (!fs2 && len < 700);
    chk("u2_post_reset_frame_len", len, 600);
    chk("u2_post_reset_pwm_high_cycles", nz, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
`default_nettype wire
